writeback_dispatcher: RTL and testbench



---
 rtl/writeback_pkg.sv | 40 ++++
 rtl/wb_rr_arbiter.sv | 37 +++
 rtl/writeback_dispatcher.sv | 140 ++++++++++++++
 tb/tb_writeback_dispatcher.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback dispatcher: channel indices, per-channel
// payload widths and byte strobes, and the dispatcher FSM state type.
package writeback_pkg;

  localparam int WB_NUM_CH = 9;

  typedef enum logic [3:0] {
    WB_CQHEAD       = 4'd0,
    WB_SQPSN        = 4'd1,
    WB_LSTRQREQ     = 4'd2,
    WB_INSRRPKTCNT  = 4'd3,
    WB_INAMPKTCNT   = 4'd4,
    WB_INNCKPKTSTS  = 4'd5,
    WB_OUTAMPKTCNT  = 4'd6,
    WB_OUTNAKPKTCNT = 4'd7,
    WB_OUTIOPKTCNT  = 4'd8
  } wb_ch_e;

  localparam int WB_CH_WIDTH [WB_NUM_CH] = '{40, 40, 40, 32, 32, 32, 32, 16, 32};

  // One strobe bit per byte the payload occupies.
  function automatic logic [7:0] wb_width_strb(input int width);
    return 8'((1 << ((width + 7) / 8)) - 1);
  endfunction

  localparam logic [7:0] WB_CH_STRB [WB_NUM_CH] = '{
    wb_width_strb(WB_CH_WIDTH[0]), wb_width_strb(WB_CH_WIDTH[1]),
    wb_width_strb(WB_CH_WIDTH[2]), wb_width_strb(WB_CH_WIDTH[3]),
    wb_width_strb(WB_CH_WIDTH[4]), wb_width_strb(WB_CH_WIDTH[5]),
    wb_width_strb(WB_CH_WIDTH[6]), wb_width_strb(WB_CH_WIDTH[7]),
    wb_width_strb(WB_CH_WIDTH[8])
  };

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel at or
// after ptr, wrapping modulo NUM_CH. The pointer register lives in the parent.
module wb_rr_arbiter
  import writeback_pkg::*;
#(
  parameter int NUM_CH = WB_NUM_CH,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  localparam logic [PTR_W:0] NUM_CH_X = (PTR_W+1)'(NUM_CH);

  logic [PTR_W:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= NUM_CH_X) cand = cand - NUM_CH_X;
      if (req[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/writeback_dispatcher.sv
// Holds the latest value per writeback channel and issues one host-memory write
// per value, round-robin. Optional error counter: define WB_ERR_CNT_EN.
module writeback_dispatcher
  import writeback_pkg::*;
#(
  parameter int NUM_CH = WB_NUM_CH,
  parameter int DATA_W = 40,
  parameter int ADDR_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_CH-1:0]        wb_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] wb_data_i,
  output logic                     wb_ready_o,
  input  logic [NUM_CH-1:0]        wb_en_i,
  input  logic [NUM_CH*ADDR_W-1:0] wb_addr_i,
  output logic                     wr_req_valid_o,
  input  logic                     wr_req_ready_i,
  output logic [ADDR_W-1:0]        wr_req_addr_o,
  output logic [63:0]              wr_req_data_o,
  output logic [7:0]               wr_req_strb_o,
  input  logic                     wr_resp_valid_i,
  input  logic                     wr_resp_err_i,
  output logic [15:0]              err_cnt_o
);

  localparam int PTR_W = $clog2(NUM_CH);

  wb_state_e                      state;
  logic [NUM_CH-1:0]              pend;
  logic [NUM_CH-1:0]              pend_nxt;
  logic [NUM_CH-1:0]              req;
  logic [NUM_CH-1:0]              gnt;
  logic [NUM_CH-1:0]              cap;
  logic [NUM_CH-1:0][DATA_W-1:0]  cap_data;
  logic [NUM_CH-1:0][DATA_W-1:0]  hold;
  logic [PTR_W-1:0]               rr_ptr;
  logic [PTR_W-1:0]               gnt_idx;
  logic                           gnt_any;
  logic                           issue;
  logic                           ready_q;

  assign cap        = wb_valid_i & wb_en_i;
  assign req        = pend & wb_en_i;
  assign issue      = (state == ST_IDLE) && gnt_any;
  assign wb_ready_o = ready_q;

  // Narrow channels are zero-extended so stray upper bits never reach the host.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cap
    localparam logic [DATA_W-1:0] CH_MASK = (WB_CH_WIDTH[ch] >= DATA_W) ? {DATA_W{1'b1}}
                                          : DATA_W'((64'd1 << WB_CH_WIDTH[ch]) - 64'd1);
    assign cap_data[ch] = wb_data_i[ch*DATA_W +: DATA_W] & CH_MASK;
  end

  wb_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // A capture in the grant cycle re-arms pend, so the newer value goes out next.
  always_comb begin
    pend_nxt = req;
    if (issue) pend_nxt = pend_nxt & ~gnt;
    pend_nxt = pend_nxt | cap;
  end

  always_ff @(posedge clk_i) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cap[ch]) hold[ch] <= cap_data[ch];
    end
  end

  // ---- request stage: grant latches address/data/strobe into the output registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state          <= ST_IDLE;
      pend           <= '0;
      rr_ptr         <= '0;
      ready_q        <= 1'b0;
      wr_req_valid_o <= 1'b0;
      wr_req_addr_o  <= '0;
      wr_req_data_o  <= '0;
      wr_req_strb_o  <= '0;
    end else begin
      ready_q <= 1'b1;
      pend    <= pend_nxt;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            wr_req_addr_o  <= wb_addr_i[gnt_idx*ADDR_W +: ADDR_W];
            wr_req_data_o  <= 64'(hold[gnt_idx]);
            wr_req_strb_o  <= WB_CH_STRB[gnt_idx];
            wr_req_valid_o <= 1'b1;
            rr_ptr         <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wr_req_ready_i) begin
            wr_req_valid_o <= 1'b0;
            state          <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (wr_resp_valid_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_ERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      err_cnt <= '0;
    end else if ((state == ST_WAIT_RESP) && wr_resp_valid_i && wr_resp_err_i) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign err_cnt_o = err_cnt;
`else
  logic unused_resp_err;
  assign unused_resp_err = wr_resp_err_i;
  assign err_cnt_o       = 16'h0000;
`endif

endmodule

// File: tb/tb_writeback_dispatcher.sv
// Bench for writeback_dispatcher: directed steps plus randomized batches checked
// against a transaction-level model (latest value per channel, RR order from pointer).
`timescale 1ns/1ps
module tb_writeback_dispatcher;

  localparam int NCH = 9;
  localparam int DW  = 40;
  localparam int AW  = 64;
  localparam int CH_W [NCH] = '{40, 40, 40, 32, 32, 32, 32, 16, 32};

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [NCH-1:0]    wb_valid_i;
  logic [NCH*DW-1:0] wb_data_i;
  logic              wb_ready_o;
  logic [NCH-1:0]    wb_en_i;
  logic [NCH*AW-1:0] wb_addr_i;
  logic              wr_req_valid_o;
  logic              wr_req_ready_i;
  logic [AW-1:0]     wr_req_addr_o;
  logic [63:0]       wr_req_data_o;
  logic [7:0]        wr_req_strb_o;
  logic              wr_resp_valid_i;
  logic              wr_resp_err_i;
  logic [15:0]       err_cnt_o;

  always #5 clk = ~clk;

  writeback_dispatcher dut (
    .clk_i           (clk),
    .rstn_i          (rstn_i),
    .wb_valid_i      (wb_valid_i),
    .wb_data_i       (wb_data_i),
    .wb_ready_o      (wb_ready_o),
    .wb_en_i         (wb_en_i),
    .wb_addr_i       (wb_addr_i),
    .wr_req_valid_o  (wr_req_valid_o),
    .wr_req_ready_i  (wr_req_ready_i),
    .wr_req_addr_o   (wr_req_addr_o),
    .wr_req_data_o   (wr_req_data_o),
    .wr_req_strb_o   (wr_req_strb_o),
    .wr_resp_valid_i (wr_resp_valid_i),
    .wr_resp_err_i   (wr_resp_err_i),
    .err_cnt_o       (err_cnt_o)
  );

  int          total = 0;
  int          bad   = 0;
  int          model_ptr = 0;
  int          err_total = 0;
  bit          err_mode = 1'b0;
  bit          err_rand = 1'b0;
  bit          hs_seen  = 1'b0;
  logic [63:0] log_addr [$];
  logic [63:0] log_data [$];
  logic [7:0]  log_strb [$];

  function automatic logic [63:0] exp_data(input int ch, input logic [39:0] d);
    logic [63:0] v;
    v = 64'(d);
    if (CH_W[ch] < 64) v = v & ((64'd1 << CH_W[ch]) - 64'd1);
    return v;
  endfunction

  function automatic logic [7:0] exp_strb(input int ch);
    case (CH_W[ch])
      40:      return 8'h1F;
      32:      return 8'h0F;
      default: return 8'h03;
    endcase
  endfunction

  function automatic logic [63:0] ch_addr(input int ch);
    return 64'h1000 + 64'(ch) * 64'h40;
  endfunction

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [39:0] d);
    wb_valid_i[ch]          = 1'b1;
    wb_data_i[ch*DW +: DW]  = d;
  endtask

  task automatic clr();
    wb_valid_i = '0;
  endtask

  task automatic flush();
    log_addr.delete();
    log_data.delete();
    log_strb.delete();
  endtask

  task automatic drain(input int n, input bit rnd_ready);
    int t;
    t = 0;
    while (log_addr.size() < n && t < 400) begin
      if (rnd_ready) wr_req_ready_i = ($urandom_range(0, 3) != 0);
      step();
      t++;
    end
    wr_req_ready_i = 1'b1;
    repeat (8) step();
    chk("drain_count", 64'(log_addr.size()), 64'(n));
  endtask

  task automatic exp_write(input string tag, input int ch, input logic [39:0] d);
    logic [63:0] a;
    logic [63:0] dd;
    logic [7:0]  s;
    chk({tag, "_avail"}, 64'(log_addr.size() != 0), 64'd1);
    if (log_addr.size() != 0) begin
      a  = log_addr.pop_front();
      dd = log_data.pop_front();
      s  = log_strb.pop_front();
      chk({tag, "_addr"}, a, ch_addr(ch));
      chk({tag, "_data"}, dd, exp_data(ch, d));
      chk({tag, "_strb"}, 64'(s), 64'(exp_strb(ch)));
    end
    model_ptr = (ch + 1) % NCH;
  endtask

  task automatic chk_err_cnt(input string tag);
`ifdef WB_ERR_CNT_EN
    chk(tag, 64'(err_cnt_o), 64'(err_total > 65535 ? 65535 : err_total));
`else
    chk(tag, 64'(err_cnt_o), 64'd0);
`endif
  endtask

  // Write-port slave: logs accepted requests, answers one cycle after each handshake.
  initial begin
    wr_resp_valid_i = 1'b0;
    wr_resp_err_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_resp_valid_i) begin
        wr_resp_valid_i = 1'b0;
        wr_resp_err_i   = 1'b0;
      end else if (hs_seen) begin
        wr_resp_valid_i = 1'b1;
        wr_resp_err_i   = err_mode ? 1'b1 : (err_rand ? 1'($urandom_range(0, 1)) : 1'b0);
        if (wr_resp_err_i) err_total++;
        hs_seen = 1'b0;
      end
      if (!rstn_i) begin
        hs_seen = 1'b0;
      end else if (wr_req_valid_o && wr_req_ready_i) begin
        log_addr.push_back(wr_req_addr_o);
        log_data.push_back(wr_req_data_o);
        log_strb.push_back(wr_req_strb_o);
        hs_seen = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0]    d0;
    logic [39:0]    da;
    logic [39:0]    db;
    logic [39:0]    rd [NCH];
    logic [NCH-1:0] m;
    logic [NCH-1:0] en;
    int             order [$];

    rstn_i         = 1'b0;
    wb_valid_i     = '0;
    wb_data_i      = '0;
    wb_en_i        = '1;
    wr_req_ready_i = 1'b1;
    for (int c = 0; c < NCH; c++) wb_addr_i[c*AW +: AW] = ch_addr(c);
    repeat (3) step();
    chk("rst_valid", 64'(wr_req_valid_o), 64'd0);
    chk("rst_addr",  wr_req_addr_o, 64'd0);
    chk("rst_data",  wr_req_data_o, 64'd0);
    chk("rst_strb",  64'(wr_req_strb_o), 64'd0);
    chk("rst_err",   64'(err_cnt_o), 64'd0);
    chk("rst_ready", 64'(wb_ready_o), 64'd0);
    rstn_i    = 1'b1;
    model_ptr = 0;
    step();
    chk("ready_after_rst", 64'(wb_ready_o), 64'd1);

    // single write, latency
    put(0, 40'h12_3456_789A);
    step();
    clr();
    chk("lat_c1_valid", 64'(wr_req_valid_o), 64'd0);
    step();
    chk("lat_c2_valid", 64'(wr_req_valid_o), 64'd1);
    chk("lat_c2_addr",  wr_req_addr_o, 64'h1000);
    chk("lat_c2_data",  wr_req_data_o, 64'h12_3456_789A);
    chk("lat_c2_strb",  64'(wr_req_strb_o), 64'h1F);
    drain(1, 1'b0);
    exp_write("single", 0, 40'h12_3456_789A);
    flush();

    // coalescing on ch7 while ch0 is in flight
    d0 = rand40();
    put(0, d0);
    step();
    clr();
    put(7, 40'h1);
    step();
    clr();
    put(7, 40'h2);
    step();
    clr();
    drain(2, 1'b0);
    exp_write("coal_ch0", 0, d0);
    exp_write("coal_ch7", 7, 40'h2);
    flush();

    // round robin from pointer 5
    d0 = rand40();
    put(4, d0);
    step();
    clr();
    drain(1, 1'b0);
    exp_write("rr_setup", 4, d0);
    flush();
    for (int c = 0; c < NCH; c++) rd[c] = rand40();
    put(1, rd[1]);
    put(4, rd[4]);
    put(8, rd[8]);
    step();
    clr();
    drain(3, 1'b0);
    exp_write("rr_first",  8, rd[8]);
    exp_write("rr_second", 1, rd[1]);
    exp_write("rr_third",  4, rd[4]);
    flush();
    put(4, rd[4]);
    put(5, rd[5]);
    step();
    clr();
    drain(2, 1'b0);
    exp_write("rr_ptr5_a", 5, rd[5]);
    exp_write("rr_ptr5_b", 4, rd[4]);
    flush();

    // backpressure with a new ch2 value arriving during the stall
    da = rand40();
    db = rand40();
    wr_req_ready_i = 1'b0;
    put(2, da);
    step();
    clr();
    step();
    chk("bp_valid", 64'(wr_req_valid_o), 64'd1);
    put(2, db);
    for (int i = 0; i < 10; i++) begin
      step();
      clr();
      chk("bp_hold_valid", 64'(wr_req_valid_o), 64'd1);
      chk("bp_hold_addr",  wr_req_addr_o, ch_addr(2));
      chk("bp_hold_data",  wr_req_data_o, exp_data(2, da));
      chk("bp_hold_strb",  64'(wr_req_strb_o), 64'(exp_strb(2)));
    end
    wr_req_ready_i = 1'b1;
    drain(2, 1'b0);
    exp_write("bp_old", 2, da);
    exp_write("bp_new", 2, db);
    flush();

    // disabled channel is dropped
    wb_en_i[3] = 1'b0;
    put(3, rand40());
    step();
    clr();
    repeat (6) step();
    wb_en_i[3] = 1'b1;
    drain(0, 1'b0);
    flush();

    // clearing enable while pending drops the pending value
    d0 = rand40();
    wr_req_ready_i = 1'b0;
    put(0, d0);
    step();
    clr();
    put(6, rand40());
    step();
    clr();
    wb_en_i[6] = 1'b0;
    step();
    wb_en_i[6] = 1'b1;
    step();
    wr_req_ready_i = 1'b1;
    drain(1, 1'b0);
    exp_write("en_clr", 0, d0);
    flush();

    // capture on ch2 in the same cycle it is granted
    da = rand40();
    db = rand40();
    put(2, da);
    step();
    clr();
    put(2, db);
    step();
    clr();
    drain(2, 1'b0);
    exp_write("same_old", 2, da);
    exp_write("same_new", 2, db);
    flush();

    // reset while a request is stalled
    wr_req_ready_i = 1'b0;
    put(1, rand40());
    put(5, rand40());
    step();
    clr();
    step();
    chk("rreq_valid", 64'(wr_req_valid_o), 64'd1);
    rstn_i = 1'b0;
    step();
    chk("rreq_valid_low", 64'(wr_req_valid_o), 64'd0);
    chk("rreq_addr",      wr_req_addr_o, 64'd0);
    chk("rreq_data",      wr_req_data_o, 64'd0);
    chk("rreq_ready",     64'(wb_ready_o), 64'd0);
    rstn_i         = 1'b1;
    wr_req_ready_i = 1'b1;
    model_ptr      = 0;
    err_total      = 0;
    step();
    drain(0, 1'b0);
    flush();
    da = rand40();
    db = rand40();
    put(8, da);
    put(0, db);
    step();
    clr();
    drain(2, 1'b0);
    exp_write("post_rst_a", 0, db);
    exp_write("post_rst_b", 8, da);
    flush();

    // error responses
    err_mode = 1'b1;
    for (int c = 0; c < 3; c++) rd[c] = rand40();
    for (int c = 0; c < 3; c++) put(c, rd[c]);
    step();
    clr();
    drain(3, 1'b0);
    for (int c = 0; c < 3; c++) exp_write("err", c, rd[c]);
    flush();
    err_mode = 1'b0;
    chk_err_cnt("err_cnt3");

    // randomized batches with random enables, stalls and error responses
    err_rand = 1'b1;
    for (int it = 0; it < 25; it++) begin
      m  = NCH'($urandom);
      en = NCH'($urandom) | NCH'($urandom);
      wb_en_i = en;
      for (int c = 0; c < NCH; c++) begin
        rd[c] = rand40();
        if (m[c]) put(c, rd[c]);
      end
      step();
      clr();
      order.delete();
      for (int k = 0; k < NCH; k++) begin
        if (m[(model_ptr + k) % NCH] && en[(model_ptr + k) % NCH]) order.push_back((model_ptr + k) % NCH);
      end
      drain(order.size(), 1'b1);
      for (int k = 0; k < order.size(); k++) exp_write("rnd", order[k], rd[order[k]]);
      flush();
      wb_en_i = '1;
    end
    err_rand = 1'b0;
    chk_err_cnt("err_cnt_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
